// File: rtl/clock_hex_display.sv
// Converts hour/minute/second to BCD with a double-dabble engine and drives six 7-seg digits as HH.MM.SS.
// Latency 7 cycles from the detecting edge to update; no backpressure, inputs are sampled levels.
module clock_hex_display #(
  parameter bit BLANK_HOUR_LZ = 1'b0,
  parameter bit DP_BLINK      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] second,
  input  logic [5:0] minute,
  input  logic [5:0] hour,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5,
  output logic       update
);

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  state_t      state;
  logic [5:0]  cmt_h, cmt_m, cmt_s;
  logic        cmt_valid;
  logic [13:0] sr_h, sr_m, sr_s;
  logic [2:0]  iter;
  logic [7:0]  hex0_n, hex1_n, hex2_n, hex3_n, hex4_n, hex5_n;
  logic        change;

  // One shift-add-3 iteration on {tens, ones, binary}.
  function automatic logic [13:0] dd_step(input logic [13:0] sr);
    logic [13:0] t;
    t = sr;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    if (t[9:6]   >= 4'd5) t[9:6]   = t[9:6]   + 4'd3;
    return {t[12:0], 1'b0};
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign change = !cmt_valid || (hour != cmt_h) || (minute != cmt_m) || (second != cmt_s);

  // Range check works on the latched values, not on the live inputs.
  always_comb begin
    hex5_n = seg7(sr_h[13:10]);
    hex4_n = seg7(sr_h[9:6]);
    hex3_n = seg7(sr_m[13:10]);
    hex2_n = seg7(sr_m[9:6]);
    hex1_n = seg7(sr_s[13:10]);
    hex0_n = seg7(sr_s[9:6]);
    if (cmt_h > 6'd23) begin
      hex5_n = SEG_DASH;
      hex4_n = SEG_DASH;
    end else if (BLANK_HOUR_LZ && (sr_h[13:10] == 4'd0)) begin
      hex5_n = SEG_BLANK;
    end
    if (cmt_m > 6'd59) begin
      hex3_n = SEG_DASH;
      hex2_n = SEG_DASH;
    end
    if (cmt_s > 6'd59) begin
      hex1_n = SEG_DASH;
      hex0_n = SEG_DASH;
    end
    if (!DP_BLINK || !cmt_s[0]) begin
      hex4_n[7] = 1'b0;
      hex2_n[7] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmt_h     <= '0;
      cmt_m     <= '0;
      cmt_s     <= '0;
      cmt_valid <= 1'b0;
      sr_h      <= '0;
      sr_m      <= '0;
      sr_s      <= '0;
      iter      <= '0;
      HEX0      <= SEG_BLANK;
      HEX1      <= SEG_BLANK;
      HEX2      <= SEG_BLANK;
      HEX3      <= SEG_BLANK;
      HEX4      <= SEG_BLANK;
      HEX5      <= SEG_BLANK;
      update    <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        IDLE: begin
          if (change) begin
            cmt_h <= hour;
            cmt_m <= minute;
            cmt_s <= second;
            sr_h  <= {8'b0, hour};
            sr_m  <= {8'b0, minute};
            sr_s  <= {8'b0, second};
            iter  <= '0;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          sr_h <= dd_step(sr_h);
          sr_m <= dd_step(sr_m);
          sr_s <= dd_step(sr_s);
          iter <= iter + 3'd1;
          if (iter == 3'd5) state <= COMMIT;
        end
        COMMIT: begin
          HEX0      <= hex0_n;
          HEX1      <= hex1_n;
          HEX2      <= hex2_n;
          HEX3      <= hex3_n;
          HEX4      <= hex4_n;
          HEX5      <= hex5_n;
          update    <= 1'b1;
          cmt_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_hex_display.sv
// Scoreboarded bench for clock_hex_display: default instance plus one with leading-zero blanking and steady DPs.
module tb_clock_hex_display;

  logic       clk;
  logic       rst_n;
  logic [5:0] second, minute, hour;
  logic [7:0] a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5;
  logic       upd_a, upd_b;

  clock_hex_display dut_a (
    .clk(clk), .rst_n(rst_n), .second(second), .minute(minute), .hour(hour),
    .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3), .HEX4(a4), .HEX5(a5), .update(upd_a)
  );

  clock_hex_display #(.BLANK_HOUR_LZ(1'b1), .DP_BLINK(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .second(second), .minute(minute), .hour(hour),
    .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3), .HEX4(b4), .HEX5(b5), .update(upd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [47:0] hex_a;
    logic [47:0] hex_b;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pcount = 0;
  int          busy = 0;
  bit          m_valid = 0;
  int          m_h, m_m, m_s;
  logic [47:0] shown_a = '1;
  logic [47:0] shown_b = '1;
  logic [47:0] hex_a, hex_b;

  assign hex_a = {a5, a4, a3, a2, a1, a0};
  assign hex_b = {b5, b4, b3, b2, b1, b0};

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Display derived directly from the clock value with decimal arithmetic.
  function automatic logic [47:0] expect_hex(input int h, input int m, input int s,
                                             input bit blank_lz, input bit dp_blink);
    logic [7:0] tbl [10];
    logic [7:0] d [6];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    if (s > 59) begin d[1] = 8'hBF; d[0] = 8'hBF; end
    else begin d[1] = tbl[s / 10]; d[0] = tbl[s % 10]; end
    if (m > 59) begin d[3] = 8'hBF; d[2] = 8'hBF; end
    else begin d[3] = tbl[m / 10]; d[2] = tbl[m % 10]; end
    if (h > 23) begin d[5] = 8'hBF; d[4] = 8'hBF; end
    else begin
      d[5] = (blank_lz && h < 10) ? 8'hFF : tbl[h / 10];
      d[4] = tbl[h % 10];
    end
    if (!dp_blink || (s % 2 == 0)) begin
      d[4] = d[4] & 8'h7F;
      d[2] = d[2] & 8'h7F;
    end
    return {d[5], d[4], d[3], d[2], d[1], d[0]};
  endfunction

  // Reference timing: a change is seen only when the previous job (7 edges) is finished.
  always @(posedge clk) begin
    exp_t e;
    pcount++;
    if (!rst_n) begin
      busy    = 0;
      m_valid = 0;
      sb_q.delete();
    end else if (busy > 0) begin
      busy--;
    end else if (!m_valid || hour != m_h || minute != m_m || second != m_s) begin
      m_valid = 1;
      m_h = hour; m_m = minute; m_s = second;
      busy = 7;
      e.cyc   = pcount + 7;
      e.hex_a = expect_hex(m_h, m_m, m_s, 1'b0, 1'b1);
      e.hex_b = expect_hex(m_h, m_m, m_s, 1'b1, 1'b0);
      sb_q.push_back(e);
    end
  end

  // Monitor: pops on every update and checks the held display every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      shown_a = '1;
      shown_b = '1;
      if (upd_a || upd_b) chk("update_in_reset", {46'd0, upd_a, upd_b}, 48'd0);
    end else if (upd_a || upd_b) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_update", {46'd0, upd_a, upd_b}, 48'd0);
      end else begin
        e = sb_q.pop_front();
        chk("update_both", {46'd0, upd_a, upd_b}, 48'd3);
        chk("latency", 48'(pcount), 48'(e.cyc));
        shown_a = e.hex_a;
        shown_b = e.hex_b;
      end
    end
    chk("hex_a", hex_a, shown_a);
    chk("hex_b", hex_b, shown_b);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour = 6'(h); minute = 6'(m); second = 6'(s);
  endtask

  initial begin
    rst_n = 1'b0;
    set_time(8, 13, 0);
    tick(3);
    rst_n = 1'b1;
    tick(12);
    set_time(8, 13, 1);
    tick(12);
    set_time(23, 59, 59);
    tick(12);
    set_time(0, 0, 0);
    tick(12);
    set_time(24, 60, 61);
    tick(12);
    set_time(10, 20, 30);
    tick(12);
    set_time(11, 21, 31);
    tick(3);
    set_time(12, 22, 32);
    tick(20);
    // Abort a conversion with reset: outputs blank at once, nothing commits.
    set_time(5, 6, 7);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("abort_blank_a", hex_a, 48'hFFFF_FFFF_FFFF);
    chk("abort_blank_b", hex_b, 48'hFFFF_FFFF_FFFF);
    tick(4);
    rst_n = 1'b1;
    tick(12);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0)
        set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      tick($urandom_range(1, 12));
    end
    tick(20);
    chk("drain", 48'(sb_q.size()), 48'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
